// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master Wishbone arbiter sharing one slave-side bus.
// M0 is instruction fetch, M1 is load/store. One transfer per grant,
// round-robin or fixed (M0 first) arbitration, and a watchdog that completes
// any transfer the slave never acknowledges.
//
// Bundle layouts (flattened):
//   request  [70:0] = {addr[31:0], data[31:0], sel[3:0], cyc, stb, we}
//   response [32:0] = {data[31:0], ack}
module wb_arbiter2 #(
   parameter int PRIORITY = 0,   // 0 = round-robin, 1 = fixed priority (M0 wins)
   parameter int TIMEOUT  = 255  // granted cycles without ack before the watchdog fires (2..65535)
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [70:0] i_m0_wb,
   output logic [32:0] o_m0_wb,
   input  logic [70:0] i_m1_wb,
   output logic [32:0] o_m1_wb,
   output logic [70:0] o_s_wb,
   input  logic [32:0] i_s_wb,
   output logic [1:0]  o_grant,
   output logic        o_timeout
);

   // Bit positions inside the request bundle.
   localparam int CYC_BIT = 2;
   localparam int STB_BIT = 1;

   // Counter value seen during the TIMEOUT-th granted cycle.
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        last;       // master granted most recently (0 = M0, 1 = M1)
   logic [15:0] wd_count;   // granted cycles elapsed in the current transfer

   logic        req0;
   logic        req1;
   logic        s_ack;
   logic [31:0] s_data;
   logic        wd_fire;
   logic        done;
   logic [31:0] resp_data;

   assign req0   = i_m0_wb[CYC_BIT] & i_m0_wb[STB_BIT];
   assign req1   = i_m1_wb[CYC_BIT] & i_m1_wb[STB_BIT];
   assign s_ack  = i_s_wb[0];
   assign s_data = i_s_wb[32:1];

   // A real slave ack always beats the watchdog in the same cycle.
   assign wd_fire   = (state != IDLE) && (wd_count == WD_LAST) && !s_ack;
   assign done      = s_ack | wd_fire;
   assign resp_data = wd_fire ? 32'h0000_0000 : s_data;

   // State register, round-robin history and watchdog counter.
   // NOTE: every register here uses <= so all of them sample the same
   // pre-edge values; a blocking write would leak new values into later lines.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         last     <= 1'b1;   // so M0 wins the first tie
         wd_count <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE) begin
            wd_count <= '0;
            if (state_next == GNT0) begin
               last <= 1'b0;
            end else if (state_next == GNT1) begin
               last <= 1'b1;
            end
         end else begin
            wd_count <= wd_count + 16'd1;
         end
      end
   end

   // Next-state selection, slave-side mux and response routing.
   // NOTE: every output gets a default before the case so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      o_s_wb     = '0;
      o_grant    = 2'b00;
      o_m0_wb    = {resp_data, 1'b0};
      o_m1_wb    = {resp_data, 1'b0};
      o_timeout  = wd_fire;

      case (state)
         IDLE: begin
            if (req0 && req1) begin
               state_next = ((PRIORITY != 0) || last) ? GNT0 : GNT1;
            end else if (req0) begin
               state_next = GNT0;
            end else if (req1) begin
               state_next = GNT1;
            end
         end
         GNT0: begin
            o_s_wb     = i_m0_wb;
            o_grant    = 2'b01;
            o_m0_wb[0] = done;
            if (done || !i_m0_wb[CYC_BIT]) begin
               state_next = IDLE;
            end
         end
         GNT1: begin
            o_s_wb     = i_m1_wb;
            o_grant    = 2'b10;
            o_m1_wb[0] = done;
            if (done || !i_m1_wb[CYC_BIT]) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: a round-robin instance and a fixed-priority instance
// share the master stimulus; each has its own scripted slave. A transfer-level
// model checks every output of both instances on every cycle, and directed
// sequences pin the model with hand-computed literal expectations.
module tb_wb_arbiter2;

   localparam int TMO = 4;
   localparam int CYC = 2;
   localparam int STB = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [70:0] m0;
   logic [70:0] m1;
   logic [70:0] s_req [2];
   logic [32:0] s_rsp [2];
   logic [32:0] r0 [2];
   logic [32:0] r1 [2];
   logic [1:0]  grant [2];
   logic        tmo [2];

   int          slave_wait = -1;          // -1 = slave never acks
   logic [31:0] slave_data = 32'h0;
   int          scnt [2];

   int tests = 0;
   int fails = 0;

   // Instance 0: round-robin. Instance 1: fixed priority.
   wb_arbiter2 #(.PRIORITY(0), .TIMEOUT(TMO)) u_rr (
      .i_clk(clk), .i_rst(rst),
      .i_m0_wb(m0), .o_m0_wb(r0[0]),
      .i_m1_wb(m1), .o_m1_wb(r1[0]),
      .o_s_wb(s_req[0]), .i_s_wb(s_rsp[0]),
      .o_grant(grant[0]), .o_timeout(tmo[0])
   );

   wb_arbiter2 #(.PRIORITY(1), .TIMEOUT(TMO)) u_fp (
      .i_clk(clk), .i_rst(rst),
      .i_m0_wb(m0), .o_m0_wb(r0[1]),
      .i_m1_wb(m1), .o_m1_wb(r1[1]),
      .o_s_wb(s_req[1]), .i_s_wb(s_rsp[1]),
      .o_grant(grant[1]), .o_timeout(tmo[1])
   );

   // Slaves: ack after slave_wait wait cycles of a held request.
   for (genvar k = 0; k < 2; k++) begin : g_slave
      assign s_rsp[k] = {slave_data,
                         s_req[k][CYC] && s_req[k][STB] && (slave_wait >= 0) && (scnt[k] == slave_wait)};
      always @(posedge clk) begin
         if (rst || !(s_req[k][CYC] && s_req[k][STB]) || s_rsp[k][0]) scnt[k] <= 0;
         else scnt[k] <= scnt[k] + 1;
      end
   end

   task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual 'h%0h required 'h%0h", name, act, exp);
      end
   endtask

   // ---------------- transfer-level model ----------------
   int          owner [2]  = '{-1, -1};  // -1 idle, else granted master
   int          age [2]    = '{0, 0};    // 1-based granted cycle number
   int          last_w [2] = '{1, 1};
   bit          mvalid     = 1'b0;
   logic        m_sack, m_dog, m_req0, m_req1, m_cyc;
   logic [1:0]  m_grant;
   logic [70:0] m_sreq;
   logic [31:0] m_data;
   int          m_win;

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         m_sack = s_rsp[k][0];
         m_req0 = m0[CYC] && m0[STB];
         m_req1 = m1[CYC] && m1[STB];
         m_dog  = (owner[k] >= 0) && (age[k] == TMO) && !m_sack;
         if (mvalid) begin
            m_grant = (owner[k] == 0) ? 2'b01 : (owner[k] == 1) ? 2'b10 : 2'b00;
            m_sreq  = (owner[k] == 0) ? m0 : (owner[k] == 1) ? m1 : 71'h0;
            m_data  = m_dog ? 32'h0 : slave_data;
            check($sformatf("model_grant[%0d]", k), 71'(grant[k]), 71'(m_grant));
            check($sformatf("model_sreq[%0d]", k), s_req[k], m_sreq);
            check($sformatf("model_m0rsp[%0d]", k), 71'(r0[k]),
                  71'({m_data, (owner[k] == 0) && (m_sack || m_dog)}));
            check($sformatf("model_m1rsp[%0d]", k), 71'(r1[k]),
                  71'({m_data, (owner[k] == 1) && (m_sack || m_dog)}));
            check($sformatf("model_timeout[%0d]", k), 71'(tmo[k]), 71'(m_dog));
         end
         // advance to the state after the coming edge
         if (rst) begin
            owner[k]  = -1;
            age[k]    = 0;
            last_w[k] = 1;
         end else if (owner[k] < 0) begin
            m_win = -1;
            if (m_req0 && m_req1) m_win = (k == 1) ? 0 : 1 - last_w[k];
            else if (m_req0)      m_win = 0;
            else if (m_req1)      m_win = 1;
            if (m_win >= 0) begin
               owner[k]  = m_win;
               last_w[k] = m_win;
               age[k]    = 1;
            end
         end else begin
            m_cyc = (owner[k] == 0) ? m0[CYC] : m1[CYC];
            if (m_sack || m_dog || !m_cyc) owner[k] = -1;
            else age[k] = age[k] + 1;
         end
      end
      if (rst) mvalid = 1'b1;
   end

   // ---------------- directed stimulus ----------------
   function automatic logic [70:0] make_req(input logic [31:0] a, input logic [31:0] d,
                                            input logic [3:0] s, input logic we);
      return {a, d, s, 1'b1, 1'b1, we};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m0  = '0;
      m1  = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0]  trace0 [16];
      logic [1:0]  trace1 [16];
      logic [1:0]  exp_rr [8];
      logic [31:0] gdata;
      logic        got, m1ack, tmo_at_ack;
      int          gcnt, tcount, cnt01, cnt10;

      rst = 1'b1;
      m0  = '0;
      m1  = '0;
      do_reset();

      // Reset state
      @(negedge clk);
      check("reset_grant", 71'(grant[0]), 71'(2'b00));
      check("reset_scyc", 71'(s_req[0][CYC]), 71'(1'b0));
      check("reset_acks", 71'({r0[0][0], r1[0][0], tmo[0]}), 71'(3'b000));

      // T1: M0 read, slave acks after 2 wait cycles
      tick();
      slave_wait = 2;
      slave_data = 32'hCAFE_0001;
      m0 = make_req(32'h0000_0100, 32'h0, 4'hF, 1'b0);
      gcnt = 0; got = 1'b0; m1ack = 1'b0; gdata = '0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (grant[0] == 2'b01) gcnt++;
         if (r1[0][0]) m1ack = 1'b1;
         if (r0[0][0]) begin
            got   = 1'b1;
            gdata = r0[0][32:1];
         end
      end
      check("t1_ack_seen", 71'(got), 71'(1'b1));
      check("t1_ack_data", 71'(gdata), 71'(32'hCAFE_0001));
      check("t1_grant_cycles", 71'(gcnt), 71'(3));
      check("t1_m1_ack", 71'(m1ack), 71'(1'b0));
      tick();
      m0 = '0;
      @(negedge clk);
      check("t1_idle_after", 71'(grant[0]), 71'(2'b00));

      // T2: simultaneous continuous requests, zero-wait slave
      do_reset();
      slave_wait = 0;
      slave_data = 32'h5A5A_0002;
      m0 = make_req(32'h0000_0200, 32'h0, 4'hF, 1'b0);
      m1 = make_req(32'h0000_0300, 32'h1111_2222, 4'h3, 1'b1);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         trace0[i] = grant[0];
         trace1[i] = grant[1];
      end
      exp_rr = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
      for (int i = 0; i < 8; i++) check($sformatf("t2_rr_trace%0d", i), 71'(trace0[i]), 71'(exp_rr[i]));
      cnt01 = 0; cnt10 = 0;
      for (int i = 0; i < 16; i++) begin
         if (trace1[i] == 2'b01) cnt01++;
         if (trace1[i] == 2'b10) cnt10++;
      end
      check("t2_fp_m1_grants", 71'(cnt10), 71'(0));
      check("t2_fp_m0_grants", 71'(cnt01), 71'(8));
      tick();
      m0 = '0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (grant[1] == 2'b10) got = 1'b1;
      end
      check("t2_fp_m1_after_m0_idle", 71'(got), 71'(1'b1));
      tick();
      m1 = '0;

      // T3: M1 write to a dead slave, watchdog completes it
      do_reset();
      slave_wait = -1;
      slave_data = 32'hDEAD_BEEF;
      m1 = make_req(32'h0000_2000, 32'h1234_5678, 4'hF, 1'b1);
      gcnt = 0; tcount = 0; got = 1'b0; gdata = 32'hFFFF_FFFF; tmo_at_ack = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (grant[0] == 2'b10) begin
            gcnt++;
            if (gcnt == 1) check("t3_slave_req", s_req[0], m1);
         end
         if (tmo[0]) tcount++;
         if (r1[0][0]) begin
            got        = 1'b1;
            gdata      = r1[0][32:1];
            tmo_at_ack = tmo[0];
         end
      end
      check("t3_ack_seen", 71'(got), 71'(1'b1));
      check("t3_ack_data", 71'(gdata), 71'(32'h0));
      check("t3_ack_cycle", 71'(gcnt), 71'(TMO));
      check("t3_timeout_with_ack", 71'(tmo_at_ack), 71'(1'b1));
      tick();
      m1 = '0;
      @(negedge clk);
      if (tmo[0]) tcount++;
      check("t3_idle_after", 71'(grant[0]), 71'(2'b00));
      check("t3_timeout_pulses", 71'(tcount), 71'(1));

      // T4: slave ack coincides with the watchdog cycle
      do_reset();
      slave_wait = TMO - 1;
      slave_data = 32'hBEEF_0004;
      m0 = make_req(32'h0000_0400, 32'h0, 4'hF, 1'b0);
      gcnt = 0; tcount = 0; got = 1'b0; gdata = '0; tmo_at_ack = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (grant[0] == 2'b01) gcnt++;
         if (tmo[0]) tcount++;
         if (r0[0][0]) begin
            got        = 1'b1;
            gdata      = r0[0][32:1];
            tmo_at_ack = tmo[0];
         end
      end
      check("t4_ack_seen", 71'(got), 71'(1'b1));
      check("t4_ack_data", 71'(gdata), 71'(32'hBEEF_0004));
      check("t4_no_timeout", 71'(tmo_at_ack), 71'(1'b0));
      check("t4_ack_cycle", 71'(gcnt), 71'(TMO));
      check("t4_timeout_pulses", 71'(tcount), 71'(0));
      tick();
      m0 = '0;

      // T5: reset mid-GNT1, then a tie goes to M0
      do_reset();
      slave_wait = -1;
      slave_data = 32'h0000_0005;
      m1 = make_req(32'h0000_3000, 32'h0, 4'hF, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (grant[0] == 2'b10) got = 1'b1;
      end
      check("t5_granted_m1", 71'(got), 71'(1'b1));
      tick();
      rst = 1'b1;
      m1  = '0;
      tick();
      @(negedge clk);
      check("t5_rst_scyc", 71'(s_req[0][CYC]), 71'(1'b0));
      check("t5_rst_grant", 71'(grant[0]), 71'(2'b00));
      check("t5_rst_acks", 71'({r0[0][0], r1[0][0], tmo[0]}), 71'(3'b000));
      tick();
      rst = 1'b0;
      m0 = make_req(32'h0000_0500, 32'h0, 4'hF, 1'b0);
      m1 = make_req(32'h0000_3004, 32'h0, 4'hF, 1'b0);
      got = 1'b0; gdata = '0;
      for (int i = 0; i < 5 && !got; i++) begin
         @(negedge clk);
         if (grant[0] != 2'b00) begin
            got   = 1'b1;
            gdata = 32'(grant[0]);
         end
      end
      check("t5_tie_first", 71'(gdata), 71'(2'b01));
      rst = 1'b0;
      tick();
      m0 = '0;
      m1 = '0;

      // T6: M1 drops cyc mid-grant
      do_reset();
      slave_wait = -1;
      m1 = make_req(32'h0000_4000, 32'hAAAA_5555, 4'hF, 1'b1);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (grant[0] == 2'b10) got = 1'b1;
      end
      check("t6_granted_m1", 71'(got), 71'(1'b1));
      tick();
      m1[CYC] = 1'b0;
      @(negedge clk);
      check("t6_abort_no_ack", 71'({r0[0][0], r1[0][0]}), 71'(2'b00));
      tick();
      @(negedge clk);
      check("t6_abort_scyc", 71'(s_req[0][CYC]), 71'(1'b0));
      check("t6_abort_grant", 71'(grant[0]), 71'(2'b00));
      check("t6_abort_acks", 71'({r0[0][0], r1[0][0], tmo[0]}), 71'(3'b000));
      m1 = '0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
